// File: rtl/matmul_fx.sv
// Sequential fixed-point matrix multiply O = A*B (optionally O += A*B) using one MAC unit.
// Elements are produced row-major; each takes C MAC cycles plus one write-back cycle.
module matmul_fx #(
    parameter int unsigned S = 16,
    parameter int unsigned F = 8,
    parameter int unsigned H = 2,
    parameter int unsigned W = 2,
    parameter int unsigned C = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               accum,
    input  logic               relu,
    input  logic [H*C*S-1:0]   a,
    input  logic [C*W*S-1:0]   b,
    output logic [H*W*S-1:0]   o,
    output logic               busy,
    output logic               done
);

    localparam int unsigned AW = 2*S + $clog2(C) + 1;
    localparam int unsigned IW = (H > 1) ? $clog2(H) : 1;
    localparam int unsigned JW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned KW = (C > 1) ? $clog2(C) : 1;

    localparam logic signed [AW-1:0] RND  = AW'(1) << (F - 1);
    localparam logic signed [AW-1:0] SMAX = AW'((64'sd1 <<< (S - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] SMIN = AW'(-(64'sd1 <<< (S - 1)));

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_WB,
        ST_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nx;
    logic                    r_busy;
    logic                    r_done;
    logic                    w_busy_nx;
    logic                    w_done_nx;

    logic [H*C*S-1:0]        r_a;
    logic [C*W*S-1:0]        r_b;
    logic [H*W*S-1:0]        r_o;
    logic                    r_accum;
    logic                    r_relu;
    logic [IW-1:0]           r_i;
    logic [JW-1:0]           r_j;
    logic [KW-1:0]           r_k;
    logic signed [AW-1:0]    r_acc;

    int unsigned             w_abase;
    int unsigned             w_bbase;
    int unsigned             w_obase;
    logic                    w_last;
    logic                    w_k_last;
    logic signed [S-1:0]     w_a_el;
    logic signed [S-1:0]     w_b_el;
    logic signed [S-1:0]     w_o_el;
    logic signed [2*S-1:0]   w_a_ext;
    logic signed [2*S-1:0]   w_b_ext;
    logic signed [2*S-1:0]   w_prod;
    logic signed [AW-1:0]    w_prod_ext;
    logic signed [AW-1:0]    w_o_ext;
    logic signed [AW-1:0]    w_init;
    logic signed [AW-1:0]    w_acc_base;
    logic signed [AW-1:0]    w_acc_nx;
    logic signed [AW-1:0]    w_rnd;
    logic signed [AW-1:0]    w_shr;
    logic signed [S-1:0]     w_sat;
    logic signed [S-1:0]     w_res;

    // Operand addressing for the current (i, j, k)
    always_comb begin
        w_abase  = (32'(r_i) * C + 32'(r_k)) * S;
        w_bbase  = (32'(r_k) * W + 32'(r_j)) * S;
        w_obase  = (32'(r_i) * W + 32'(r_j)) * S;
        w_last   = (r_i == IW'(H - 1)) && (r_j == JW'(W - 1));
        w_k_last = (r_k == KW'(C - 1));
    end

    assign w_a_el     = r_a[w_abase +: S];
    assign w_b_el     = r_b[w_bbase +: S];
    assign w_o_el     = r_o[w_obase +: S];
    assign w_a_ext    = {{S{w_a_el[S-1]}}, w_a_el};
    assign w_b_ext    = {{S{w_b_el[S-1]}}, w_b_el};
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = {{(AW-2*S){w_prod[2*S-1]}}, w_prod};
    assign w_o_ext    = {{(AW-S){w_o_el[S-1]}}, w_o_el};
    assign w_init     = r_accum ? (w_o_ext <<< F) : '0;
    assign w_acc_base = (r_k == '0) ? w_init : r_acc;
    assign w_acc_nx   = w_acc_base + w_prod_ext;

    // Round half up, rescale, saturate, then optional ReLU
    assign w_rnd = r_acc + RND;
    assign w_shr = w_rnd >>> F;

    always_comb begin
        w_sat = w_shr[S-1:0];
        if (w_shr > SMAX) begin
            w_sat = {1'b0, {(S-1){1'b1}}};
        end else if (w_shr < SMIN) begin
            w_sat = {1'b1, {(S-1){1'b0}}};
        end
    end

    assign w_res = (r_relu && w_sat[S-1]) ? '0 : w_sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_busy_nx  = 1'b0;
        w_done_nx  = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_state_nx = ST_MAC;
            ST_MAC:  if (w_k_last) w_state_nx = ST_WB;
            ST_WB:   w_state_nx = w_last ? ST_DONE : ST_MAC;
            ST_DONE: w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
        w_busy_nx = (w_state_nx == ST_MAC) || (w_state_nx == ST_WB);
        w_done_nx = (w_state_nx == ST_DONE);
    end

    // Operand capture, MAC accumulation and element write-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_o     <= '0;
            r_accum <= 1'b0;
            r_relu  <= 1'b0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_accum <= accum;
                        r_relu  <= relu;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_k     <= '0;
                    end
                end
                ST_MAC: begin
                    r_acc <= w_acc_nx;
                    if (!w_k_last) r_k <= r_k + KW'(1);
                end
                ST_WB: begin
                    r_o[w_obase +: S] <= w_res;
                    r_k <= '0;
                    if (r_j == JW'(W - 1)) begin
                        r_j <= '0;
                        r_i <= w_last ? '0 : r_i + IW'(1);
                    end else begin
                        r_j <= r_j + JW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o    = r_o;
    assign busy = r_busy;
    assign done = r_done;

endmodule
